// File: rtl/pipe_latch_q.sv
// Elastic pipeline latch: a small circular buffer with a registered head output and ready/valid
// handshaking. Define PIPE_LATCH_STATS_EN to build in the stall/drop statistics counters.
module pipe_latch_q #(
  parameter int unsigned WIDTH = 121,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  input  logic                       flush,
  input  logic                       ihit,
  input  logic                       dhit,
  input  logic                       dmemREN,
  input  logic                       dmemWEN,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                drop_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} occ_e;

  occ_e             state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic mem_wait, fetch_ok, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign mem_wait = (dmemREN | dmemWEN) & ~dhit;
  assign fetch_ok = ihit;
  // While RST is high the occupancy is about to be cleared, so treat it as empty.
  assign in_ready = ~mem_wait & fetch_ok & (RST | (count_q < FullCnt) | out_ready);
  assign out_valid = (state_q != StEmpty);
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign out_data = out_q;
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    out_d   = out_q;
    state_d = state_q;
    if (flush) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // The new head is the incoming word when the buffer is (or becomes) otherwise empty.
      if (push && ((count_q == '0) || (pop && (count_q == CntW'(1))))) begin
        out_d = in_data;
      end else if (pop && (count_q > CntW'(1))) begin
        out_d = mem_q[ptr_inc(head_q)];
      end
    end
    if (count_d == '0) begin
      state_d = StEmpty;
    end else if (count_d == FullCnt) begin
      state_d = StFull;
    end else begin
      state_d = StPartial;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StEmpty;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RST) mem_q[tail_q] <= in_data;
  end

`ifdef PIPE_LATCH_STATS_EN
  logic [15:0] stall_q, drop_q;
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, drop_q} + 17'(count_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (flush) drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign stall_cnt = stall_q;
  assign drop_cnt  = drop_q;
`else
  assign stall_cnt = 16'h0000;
  assign drop_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_latch_q.sv
// Directed bench for pipe_latch_q: DEPTH=2, 4 and 1 instances share the same stimulus and each
// scenario checks the instance it targets.
module tb_pipe_latch_q;

  localparam int W = 121;
`ifdef PIPE_LATCH_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic         CLK, RST, in_valid, out_ready, flush, ihit, dhit, dmemREN, dmemWEN;
  logic [W-1:0] in_data;

  logic         in_ready2, out_valid2, in_ready4, out_valid4, in_ready1, out_valid1;
  logic [W-1:0] out_data2, out_data4, out_data1;
  logic [1:0]   count2;
  logic [2:0]   count4;
  logic [0:0]   count1;
  logic [15:0]  stall2, drop2, stall4, drop4, stall1, drop1;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_latch_q #(.WIDTH(W), .DEPTH(2)) u_d2 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready), .flush(flush),
    .ihit(ihit), .dhit(dhit), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .count(count2),
    .stall_cnt(stall2), .drop_cnt(drop2)
  );

  pipe_latch_q #(.WIDTH(W), .DEPTH(4)) u_d4 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready), .flush(flush),
    .ihit(ihit), .dhit(dhit), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .count(count4),
    .stall_cnt(stall4), .drop_cnt(drop4)
  );

  pipe_latch_q #(.WIDTH(W), .DEPTH(1)) u_d1 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready), .flush(flush),
    .ihit(ihit), .dhit(dhit), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .count(count1),
    .stall_cnt(stall1), .drop_cnt(drop1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid = 1'b1; in_data = W'(32'h77);
    #1;
    n_checks++;
    if (in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready1);
    end
    cyc(); cyc();
    in_valid = 1'b0;
    n_checks++;
    if (count2 !== 2'd0 || out_valid2 !== 1'b0) begin
      n_fail++; $display("FAIL rst_state: count %0d valid %b want 0 0", count2, out_valid2);
    end
    n_checks++;
    if (out_data2 !== W'(0)) begin
      n_fail++; $display("FAIL rst_out_data: got %0h want 0", out_data2);
    end
    n_checks++;
    if (stall2 !== 16'd0 || drop2 !== 16'd0) begin
      n_fail++; $display("FAIL rst_counters: stall %0d drop %0d want 0 0", stall2, drop2);
    end
    RST = 1'b0;
    ihit = 1'b0;
    #1;
    n_checks++;
    if (in_ready2 !== 1'b0) begin
      n_fail++; $display("FAIL no_ihit_ready: got %b want 0", in_ready2);
    end
    ihit = 1'b1;
    #1;
  endtask

  task automatic test_fill_drain();
    do_reset();
    in_valid = 1'b1; in_data = W'(32'hA); out_ready = 1'b0;
    cyc();
    in_data = W'(32'hB);
    cyc();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (count2 !== 2'd2 || in_ready2 !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: count %0d ready %b want 2 0", count2, in_ready2);
    end
    n_checks++;
    if (out_data2 !== W'(32'hA) || out_valid2 !== 1'b1) begin
      n_fail++; $display("FAIL fill_head: data %0h valid %b want a 1", out_data2, out_valid2);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready2 !== 1'b1) begin
      n_fail++; $display("FAIL full_ready_with_pop: got %b want 1", in_ready2);
    end
    cyc();
    n_checks++;
    if (out_data2 !== W'(32'hB) || count2 !== 2'd1) begin
      n_fail++; $display("FAIL drain_1: data %0h count %0d want b 1", out_data2, count2);
    end
    cyc();
    out_ready = 1'b0;
    n_checks++;
    if (count2 !== 2'd0 || out_valid2 !== 1'b0 || out_data2 !== W'(32'hB)) begin
      n_fail++;
      $display("FAIL drain_2: count %0d valid %b data %0h want 0 0 b", count2, out_valid2, out_data2);
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    dmemREN = 1'b1; dhit = 1'b0; in_valid = 1'b1; in_data = W'(32'h55);
    #1;
    n_checks++;
    if (in_ready2 !== 1'b0) begin
      n_fail++; $display("FAIL stall_ready: got %b want 0", in_ready2);
    end
    cyc(); cyc(); cyc();
    n_checks++;
    if (count2 !== 2'd0) begin
      n_fail++; $display("FAIL stall_no_push: count %0d want 0", count2);
    end
    n_checks++;
    if (stall2 !== (StatsOn ? 16'd3 : 16'd0)) begin
      n_fail++; $display("FAIL stall_cnt: got %0d want %0d", stall2, StatsOn ? 3 : 0);
    end
    dhit = 1'b1;
    #1;
    n_checks++;
    if (in_ready2 !== 1'b1) begin
      n_fail++; $display("FAIL dhit_ready: got %b want 1", in_ready2);
    end
    cyc();
    in_valid = 1'b0; dmemREN = 1'b0; dhit = 1'b0;
    n_checks++;
    if (count2 !== 2'd1 || out_data2 !== W'(32'h55)) begin
      n_fail++; $display("FAIL stall_push: count %0d data %0h want 1 55", count2, out_data2);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0; in_data = W'(32'h1);
    cyc();
    in_data = W'(32'h2);
    cyc();
    n_checks++;
    if (count2 !== 2'd2) begin
      n_fail++; $display("FAIL flush_pre: count %0d want 2", count2);
    end
    in_data = W'(32'h3); out_ready = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++;
    if (count2 !== 2'd0 || out_valid2 !== 1'b0) begin
      n_fail++; $display("FAIL flush_state: count %0d valid %b want 0 0", count2, out_valid2);
    end
    n_checks++;
    if (drop2 !== (StatsOn ? 16'd2 : 16'd0)) begin
      n_fail++; $display("FAIL drop_cnt: got %0d want %0d", drop2, StatsOn ? 2 : 0);
    end
    in_valid = 1'b1; in_data = W'(32'h4);
    cyc();
    in_valid = 1'b0;
    n_checks++;
    if (count2 !== 2'd1 || out_data2 !== W'(32'h4)) begin
      n_fail++; $display("FAIL flush_after: count %0d data %0h want 1 4", count2, out_data2);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    n_checks++;
    if (count2 !== 2'd0) begin
      n_fail++; $display("FAIL flush_discard: count %0d want 0", count2);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_data = W'(32'd1);
    cyc();
    n_checks++;
    if (out_data4 !== W'(32'd1) || count4 !== 3'd1) begin
      n_fail++; $display("FAIL wrap_first: data %0h count %0d want 1 1", out_data4, count4);
    end
    for (int k = 2; k <= 10; k++) begin
      in_data = W'(k);
      cyc();
      n_checks++;
      if (out_data4 !== W'(k) || count4 !== 3'd1) begin
        n_fail++; $display("FAIL wrap_%0d: data %0h count %0d want %0h 1", k, out_data4, count4, k);
      end
    end
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;
    n_checks++;
    if (count4 !== 3'd0 || out_valid4 !== 1'b0) begin
      n_fail++; $display("FAIL wrap_drain: count %0d valid %b want 0 0", count4, out_valid4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_data = W'(k);
      cyc();
    end
    n_checks++;
    if (count4 !== 3'd3) begin
      n_fail++; $display("FAIL mid_pre: count %0d want 3", count4);
    end
    in_data = W'(32'h9); RST = 1'b1;
    cyc();
    RST = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (count4 !== 3'd0 || out_valid4 !== 1'b0 || out_data4 !== W'(0)) begin
      n_fail++;
      $display("FAIL mid_reset: count %0d valid %b data %0h want 0 0 0", count4, out_valid4, out_data4);
    end
    n_checks++;
    if (stall4 !== 16'd0 || drop4 !== 16'd0) begin
      n_fail++; $display("FAIL mid_counters: stall %0d drop %0d want 0 0", stall4, drop4);
    end
  endtask

  task automatic test_depth1();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_data = W'(32'd5);
    #1;
    n_checks++;
    if (in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL d1_ready0: got %b want 1", in_ready1);
    end
    for (int k = 5; k <= 7; k++) begin
      in_data = W'(k);
      cyc();
      n_checks++;
      if (out_data1 !== W'(k) || in_ready1 !== 1'b1 || count1 !== 1'b1) begin
        n_fail++;
        $display("FAIL d1_flow_%0d: data %0h ready %b count %0d want %0h 1 1", k, out_data1,
                 in_ready1, count1, k);
      end
    end
    out_ready = 1'b0; in_data = W'(32'd8);
    #1;
    n_checks++;
    if (in_ready1 !== 1'b0) begin
      n_fail++; $display("FAIL d1_full_ready: got %b want 0", in_ready1);
    end
    cyc();
    n_checks++;
    if (out_data1 !== W'(32'd7)) begin
      n_fail++; $display("FAIL d1_hold: data %0h want 7", out_data1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    n_checks++;
    if (count1 !== 1'b0 || out_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL d1_drain: count %0d valid %b want 0 0", count1, out_valid1);
    end
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    ihit = 1'b1; dhit = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    test_reset();
    test_fill_drain();
    test_mem_stall();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_depth1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
